filter_pixel_feeder: RTL and testbench
======================================

// Module: filter_pixel_feeder
// PURPOSE
//  Raster pixel source for the streaming 3x3 filters (sobel etc.): pops 24-bit RGB from an
//  upstream show-ahead FIFO (memory reader), presents one pixel at a time with POSX/POSY,
//  drives READY and consumes on the filter's RDEN. Inserts a READY-low gap between lines.
//  One frame per START pulse.
// PARAMETERS
//  H_PIXELS  1920  pixels per line, 2..4095
//  V_LINES   1080  lines per frame, 1..4095
//  LINE_GAP  4     READY-low cycles after each line's last pixel, 0..255
// PORTS
//  CLK         in   1   clock
//  RST         in   1   synchronous, active-high reset
//  START       in   1   pulse: begin one frame (ignored while BUSY)
//  BUSY        out  1   high from cycle after accepted START until FRAME_DONE cycle inclusive
//  FRAME_DONE  out  1   one-cycle pulse after last pixel consumed
//  ERR         out  1   sticky: RDEN seen while READY low; cleared only by RST
//  SRC_VALID   in   1   upstream FIFO non-empty; SRC_DATA valid
//  SRC_DATA    in   24  {R,G,B} head of upstream FIFO
//  SRC_RDEN    out  1   pop upstream FIFO (combinational)
//  READY       out  1   pixel on IN_R/G/B + POSX/POSY valid (registered)
//  RDEN        in   1   filter consume strobe; filter drives RDEN = READY
//  POSX        out  12  column of presented pixel
//  POSY        out  12  line of presented pixel
//  IN_R        out  8   presented pixel red
//  IN_G        out  8   presented pixel green
//  IN_B        out  8   presented pixel blue
// BEHAVIOUR
//  - Reset: state IDLE, READY/BUSY/FRAME_DONE/ERR/SRC_RDEN=0, POSX/POSY=0, IN_R/G/B=0,
//    pixel register empty, fetch/gap counters 0. RST mid-frame abandons frame; no pop in RST cycle.
//  - States: IDLE -START-> ACTIVE; ACTIVE -last pixel of line consumed, not last line-> GAP
//    (LINE_GAP=0: stay ACTIVE); GAP -gap count done-> ACTIVE; ACTIVE -last pixel of frame
//    consumed-> DONE; DONE -> IDLE (1 cycle, FRAME_DONE=1).
//  - Pixel register (1 entry, PIX_VALID): consume = READY & RDEN.
//    SRC_RDEN = BUSY_STATE & SRC_VALID & (~PIX_VALID | consume) & (fetched < H_PIXELS*V_LINES).
//    Fetch counter 24 bit; never pops beyond frame size. Prefetch allowed during GAP.
//  - READY = PIX_VALID & state==ACTIVE, registered. IN_R/G/B hold register content; unchanged
//    while READY high and RDEN low.
//  - Latency: START at edge k -> ACTIVE at k+1; pop at k+1 if SRC_VALID -> READY at k+2.
//  - Raster: on consume POSX+1; at POSX==H_PIXELS-1 -> POSX=0, POSY+1. After frame POSX=POSY=0.
//    POSX/POSY always label the presented pixel (incl. during GAP: next line, column 0).
//  - Simultaneous: consume and pop in same cycle -> register reloaded, READY stays high (1 pix/clk).
//  - SRC_VALID low mid-line: READY drops after register drains; POSX/POSY hold; no error.
//  - RDEN while READY low: ignored (no count change), ERR<=1.
//  - START while BUSY ignored; START in DONE cycle ignored.
// STRUCTURE
//  - filter_pkg: COORD_W=12, PIX_W=24, state enum {IDLE,ACTIVE,GAP,DONE}, rgb split macros.
//  - Sub-module raster_counter: POSX/POSY with advance, wrap at H_PIXELS/V_LINES, eol/eof flags.
// TESTING  (H_PIXELS=4, V_LINES=3, LINE_GAP=2 unless noted)
//  1 FIFO pre-filled 12 px 0x000001..0x00000C, RDEN=READY, START -> READY at START+2, pixels
//    in order, POSX 0..3, POSY 0..2, READY low exactly 2 cycles after px 4 and 8, FRAME_DONE once.
//  2 FIFO holds 20 px -> exactly 12 SRC_RDEN pulses; 8 remain; second START streams px 13..20+.
//  3 SRC_VALID toggling 1-of-3 cycles -> same 12 px/coords in order, no duplicates, ERR=0.
//  4 Force RDEN=1 while READY=0 in GAP -> ERR=1 sticky, POSX/POSY unchanged.
//  5 RST asserted at pixel 6 -> next cycle all outputs 0, IDLE; new START restarts POSX=POSY=0.
//  6 LINE_GAP=0, H=2,V=2 -> 4 consecutive READY cycles, coords (0,0)(1,0)(0,1)(1,1).

Source files
------------

// File: rtl/filter_pixel_feeder_pkg.sv
// rtl/filter_pixel_feeder_pkg.sv - shared types and helpers for the filter pixel feeder
package filter_pkg;

    localparam int COORD_W = 12;
    localparam int PIX_W   = 24;
    localparam int FETCH_W = 24;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        GAP    = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Split a packed {R,G,B} word into its colour channels.
    function automatic rgb_t to_rgb(input logic [PIX_W-1:0] p);
        return rgb_t'(p);
    endfunction

endpackage

// File: rtl/filter_pixel_feeder_if.sv
// rtl/filter_pixel_feeder_if.sv - upstream FIFO and filter-side pixel stream signals
interface filter_pixel_feeder_if;
    import filter_pkg::*;

    logic               SRC_VALID;
    logic [PIX_W-1:0]   SRC_DATA;
    logic               SRC_RDEN;
    logic               READY;
    logic               RDEN;
    logic [COORD_W-1:0] POSX;
    logic [COORD_W-1:0] POSY;
    logic [7:0]         IN_R;
    logic [7:0]         IN_G;
    logic [7:0]         IN_B;

    // Feeder side: pops the FIFO and presents pixels.
    modport master (
        input  SRC_VALID, SRC_DATA, RDEN,
        output SRC_RDEN, READY, POSX, POSY, IN_R, IN_G, IN_B
    );

    // FIFO/filter side.
    modport slave (
        output SRC_VALID, SRC_DATA, RDEN,
        input  SRC_RDEN, READY, POSX, POSY, IN_R, IN_G, IN_B
    );

endinterface

// File: rtl/filter_pixel_feeder_raster.sv
// rtl/filter_pixel_feeder_raster.sv - column/line counter for the presented pixel
module raster_counter
    import filter_pkg::*;
#(
    parameter int H_PIXELS = 1920,
    parameter int V_LINES  = 1080
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               advance,
    output logic [COORD_W-1:0] posx,
    output logic [COORD_W-1:0] posy,
    output logic               eol,
    output logic               eof
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(H_PIXELS - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(V_LINES - 1);

    assign eol = (posx == X_LAST);
    assign eof = eol && (posy == Y_LAST);

    // Step through the raster on each consumed pixel; wrap to origin after the frame.
    always_ff @(posedge CLK) begin
        if (RST) begin
            posx <= '0;
            posy <= '0;
        end else if (advance) begin
            if (eof) begin
                posx <= '0;
                posy <= '0;
            end else if (eol) begin
                posx <= '0;
                posy <= posy + 1'b1;
            end else begin
                posx <= posx + 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_pixel_feeder.sv
// rtl/filter_pixel_feeder.sv - raster pixel source feeding the streaming 3x3 filters
module filter_pixel_feeder
    import filter_pkg::*;
#(
    parameter int H_PIXELS = 1920,
    parameter int V_LINES  = 1080,
    parameter int LINE_GAP = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  START,
    output logic                  BUSY,
    output logic                  FRAME_DONE,
    output logic                  ERR,
    filter_pixel_feeder_if.master pix
);

    localparam logic [FETCH_W-1:0] FRAME_TOTAL = FETCH_W'(H_PIXELS * V_LINES);
    localparam logic [7:0]         GAP_LAST    = 8'((LINE_GAP > 0) ? LINE_GAP - 1 : 0);

    state_t             state_q, state_d;
    logic               pix_valid_q, pix_valid_d;
    logic [PIX_W-1:0]   pix_data_q;
    logic [FETCH_W-1:0] fetched_q;
    logic [7:0]         gap_cnt_q, gap_cnt_d;
    logic               ready_q, ready_d;
    logic               err_q;
    logic               busy_state, consume, src_rden;
    logic               eol, eof;
    logic [COORD_W-1:0] posx, posy;
    rgb_t               pix_rgb;

    assign busy_state = (state_q == ACTIVE) || (state_q == GAP);
    // READY already implies ACTIVE, so a consume is just the handshake.
    assign consume    = ready_q && pix.RDEN;
    // Refill the one-entry register when it is empty or being drained this cycle,
    // but never pull more than one frame's worth out of the FIFO.
    assign src_rden   = !RST && busy_state && pix.SRC_VALID
                        && (!pix_valid_q || consume) && (fetched_q < FRAME_TOTAL);

    raster_counter #(
        .H_PIXELS (H_PIXELS),
        .V_LINES  (V_LINES)
    ) u_raster (
        .CLK     (CLK),
        .RST     (RST),
        .advance (consume),
        .posx    (posx),
        .posy    (posy),
        .eol     (eol),
        .eof     (eof)
    );

    // Frame sequencing and the next value of the registered READY.
    always_comb begin
        state_d   = state_q;
        gap_cnt_d = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (START) state_d = ACTIVE;
            end
            ACTIVE: begin
                if (consume && eof) begin
                    state_d = DONE;
                end else if (consume && eol && (LINE_GAP != 0)) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end
            end
            GAP: begin
                if (gap_cnt_q == GAP_LAST) state_d = ACTIVE;
                else                       gap_cnt_d = gap_cnt_q + 8'd1;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        pix_valid_d = src_rden ? 1'b1 : (consume ? 1'b0 : pix_valid_q);
        ready_d     = pix_valid_d && (state_d == ACTIVE);
    end

    // State, pixel register, fetch accounting and sticky error.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= IDLE;
            pix_valid_q <= 1'b0;
            pix_data_q  <= '0;
            fetched_q   <= '0;
            gap_cnt_q   <= '0;
            ready_q     <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            pix_valid_q <= pix_valid_d;
            gap_cnt_q   <= gap_cnt_d;
            ready_q     <= ready_d;
            if (src_rden) pix_data_q <= pix.SRC_DATA;
            if (state_q == IDLE) fetched_q <= '0;
            else if (src_rden)   fetched_q <= fetched_q + 1'b1;
            if (pix.RDEN && !ready_q) err_q <= 1'b1;
        end
    end

    assign pix_rgb      = to_rgb(pix_data_q);
    assign pix.SRC_RDEN = src_rden;
    assign pix.READY    = ready_q;
    assign pix.POSX     = posx;
    assign pix.POSY     = posy;
    assign pix.IN_R     = pix_rgb.r;
    assign pix.IN_G     = pix_rgb.g;
    assign pix.IN_B     = pix_rgb.b;
    assign BUSY         = (state_q != IDLE);
    assign FRAME_DONE   = (state_q == DONE);
    assign ERR          = err_q;

endmodule

// File: tb/tb_filter_pixel_feeder.sv
// tb/tb_filter_pixel_feeder.sv - scoreboard bench for filter_pixel_feeder
module tb_filter_pixel_feeder;

    typedef struct {
        logic [23:0] data;
        logic [11:0] x;
        logic [11:0] y;
    } exp_t;

    logic CLK;
    logic RST;
    logic START_A, BUSY_A, FD_A, ERR_A;
    logic START_B, BUSY_B, FD_B, ERR_B;

    filter_pixel_feeder_if a_if ();
    filter_pixel_feeder_if b_if ();

    filter_pixel_feeder #(.H_PIXELS(4), .V_LINES(3), .LINE_GAP(2)) dut_a (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START_A),
        .BUSY       (BUSY_A),
        .FRAME_DONE (FD_A),
        .ERR        (ERR_A),
        .pix        (a_if)
    );

    filter_pixel_feeder #(.H_PIXELS(2), .V_LINES(2), .LINE_GAP(0)) dut_b (
        .CLK        (CLK),
        .RST        (RST),
        .START      (START_B),
        .BUSY       (BUSY_B),
        .FRAME_DONE (FD_B),
        .ERR        (ERR_B),
        .pix        (b_if)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          pop_cnt_a = 0, cons_cnt_a = 0, fd_cnt_a = 0;
    int          pop_cnt_b = 0, cons_cnt_b = 0, fd_cnt_b = 0;
    int          start_cyc_a = 0;
    int          exp_idx_a = 0;
    int          cons_cyc_a[$];
    int          cons_cyc_b[$];
    logic [23:0] fifo_a[$];
    exp_t        exp_a[$];
    exp_t        exp_b[$];
    logic [23:0] data_b = 24'h000100;
    bit          throttle = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive();
        a_if.SRC_VALID = (fifo_a.size() != 0) && (!throttle || (cyc % 3 == 0));
        a_if.SRC_DATA  = (fifo_a.size() != 0) ? fifo_a[0] : 24'h0;
        a_if.RDEN      = a_if.READY;
        b_if.SRC_VALID = 1'b1;
        b_if.SRC_DATA  = data_b;
        b_if.RDEN      = b_if.READY;
    endtask

    task automatic push_px_a(input logic [23:0] d);
        exp_t e;
        fifo_a.push_back(d);
        e.data = d;
        e.x    = 12'(exp_idx_a % 4);
        e.y    = 12'(exp_idx_a / 4);
        exp_a.push_back(e);
        exp_idx_a = (exp_idx_a + 1) % 12;
        drive();
    endtask

    // One clock: sample at negedge, let the edge happen, update models, drive.
    task automatic step();
        bit          pop_a, pop_b, c_a, c_b;
        exp_t        e;
        logic [23:0] tmp;
        @(negedge CLK);
        pop_a = a_if.SRC_RDEN;
        pop_b = b_if.SRC_RDEN;
        c_a   = a_if.READY && a_if.RDEN;
        c_b   = b_if.READY && b_if.RDEN;
        if (c_a) begin
            cons_cnt_a++;
            cons_cyc_a.push_back(cyc);
            if (exp_a.size() == 0) check_eq("unexpected_pix_a", 32'(c_a), 32'd0);
            else begin
                e = exp_a.pop_front();
                check_eq("pix_a", 32'({a_if.IN_R, a_if.IN_G, a_if.IN_B}), 32'(e.data));
                check_eq("posx_a", 32'(a_if.POSX), 32'(e.x));
                check_eq("posy_a", 32'(a_if.POSY), 32'(e.y));
            end
        end
        if (c_b) begin
            cons_cnt_b++;
            cons_cyc_b.push_back(cyc);
            if (exp_b.size() == 0) check_eq("unexpected_pix_b", 32'(c_b), 32'd0);
            else begin
                e = exp_b.pop_front();
                check_eq("pix_b", 32'({b_if.IN_R, b_if.IN_G, b_if.IN_B}), 32'(e.data));
                check_eq("posx_b", 32'(b_if.POSX), 32'(e.x));
                check_eq("posy_b", 32'(b_if.POSY), 32'(e.y));
            end
        end
        if (FD_A) fd_cnt_a++;
        if (FD_B) fd_cnt_b++;
        @(posedge CLK);
        #1;
        cyc++;
        if (pop_a) begin
            pop_cnt_a++;
            if (fifo_a.size() != 0) tmp = fifo_a.pop_front();
        end
        if (pop_b) begin
            pop_cnt_b++;
            data_b = data_b + 24'd1;
        end
        drive();
    endtask

    task automatic start_a();
        start_cyc_a = cyc;
        cons_cyc_a.delete();
        START_A = 1'b1;
        step();
        START_A = 1'b0;
    endtask

    task automatic wait_done_a(input int fd0, input int budget);
        int n = 0;
        while (fd_cnt_a == fd0 && n < budget) begin
            step();
            n++;
        end
        check_eq("done_timeout_a", 32'(fd_cnt_a - fd0), 32'd1);
        step();
        step();
        check_eq("done_once_a", 32'(fd_cnt_a - fd0), 32'd1);
        check_eq("busy_after_a", 32'(BUSY_A), 32'd0);
    endtask

    task automatic frame_a(input int budget);
        int fd0 = fd_cnt_a;
        start_a();
        wait_done_a(fd0, budget);
    endtask

    initial begin
        int   p0, n, base, fd0;
        exp_t e;

        RST = 1'b1;
        START_A = 1'b0;
        START_B = 1'b0;
        drive();
        repeat (3) step();
        RST = 1'b0;
        step();
        check_eq("rst_ready", 32'(a_if.READY), 32'd0);
        check_eq("rst_busy", 32'(BUSY_A), 32'd0);
        check_eq("rst_done", 32'(FD_A), 32'd0);
        check_eq("rst_err", 32'(ERR_A), 32'd0);
        check_eq("rst_pos", 32'({a_if.POSX, a_if.POSY}), 32'd0);
        check_eq("rst_rgb", 32'({a_if.IN_R, a_if.IN_G, a_if.IN_B}), 32'd0);

        // 1: full frame from a pre-filled FIFO, check latency and line gaps.
        for (int i = 1; i <= 12; i++) push_px_a(24'(i));
        frame_a(200);
        check_eq("t1_latency", 32'(cons_cyc_a[0] - start_cyc_a), 32'd2);
        check_eq("t1_line0", 32'(cons_cyc_a[3] - cons_cyc_a[0]), 32'd3);
        check_eq("t1_gap0", 32'(cons_cyc_a[4] - cons_cyc_a[3]), 32'd3);
        check_eq("t1_gap1", 32'(cons_cyc_a[8] - cons_cyc_a[7]), 32'd3);
        check_eq("t1_line2", 32'(cons_cyc_a[11] - cons_cyc_a[8]), 32'd3);
        check_eq("t1_count", 32'(cons_cyc_a.size()), 32'd12);
        check_eq("t1_err", 32'(ERR_A), 32'd0);

        // 2: deeper FIFO, frame must stop popping at frame size.
        p0 = pop_cnt_a;
        for (int i = 0; i < 20; i++) push_px_a(24'h000101 + 24'(i));
        frame_a(200);
        check_eq("t2_pops", 32'(pop_cnt_a - p0), 32'd12);
        check_eq("t2_left", 32'(fifo_a.size()), 32'd8);
        for (int i = 20; i < 24; i++) push_px_a(24'h000101 + 24'(i));
        p0 = pop_cnt_a;
        frame_a(200);
        check_eq("t2b_pops", 32'(pop_cnt_a - p0), 32'd12);
        check_eq("t2b_sb", 32'(exp_a.size()), 32'd0);

        // 3: sparse upstream data.
        throttle = 1'b1;
        for (int i = 0; i < 12; i++) push_px_a(24'hA00000 + 24'(i * 3));
        frame_a(500);
        throttle = 1'b0;
        drive();
        check_eq("t3_sb", 32'(exp_a.size()), 32'd0);
        check_eq("t3_err", 32'(ERR_A), 32'd0);

        // 4: RDEN forced during the line gap.
        for (int i = 0; i < 12; i++) push_px_a(24'h5A0000 + 24'(i));
        fd0 = fd_cnt_a;
        base = cons_cnt_a;
        start_a();
        n = 0;
        while (cons_cnt_a < base + 4 && n < 100) begin
            step();
            n++;
        end
        check_eq("t4_reach", 32'(cons_cnt_a - base), 32'd4);
        check_eq("t4_gap_ready", 32'(a_if.READY), 32'd0);
        a_if.RDEN = 1'b1;
        step();
        check_eq("t4_err", 32'(ERR_A), 32'd1);
        check_eq("t4_posx", 32'(a_if.POSX), 32'd0);
        check_eq("t4_posy", 32'(a_if.POSY), 32'd1);
        wait_done_a(fd0, 200);
        check_eq("t4_sticky", 32'(ERR_A), 32'd1);
        check_eq("t4_sb", 32'(exp_a.size()), 32'd0);

        // 5: reset in the middle of a frame.
        for (int i = 0; i < 12; i++) push_px_a(24'hC00000 + 24'(i));
        base = cons_cnt_a;
        start_a();
        n = 0;
        while (cons_cnt_a < base + 6 && n < 100) begin
            step();
            n++;
        end
        check_eq("t5_reach", 32'(cons_cnt_a - base), 32'd6);
        RST = 1'b1;
        a_if.RDEN = 1'b0;
        #2;
        check_eq("t5_no_pop", 32'(a_if.SRC_RDEN), 32'd0);
        step();
        RST = 1'b0;
        check_eq("t5_ready", 32'(a_if.READY), 32'd0);
        check_eq("t5_busy", 32'(BUSY_A), 32'd0);
        check_eq("t5_err", 32'(ERR_A), 32'd0);
        check_eq("t5_pos", 32'({a_if.POSX, a_if.POSY}), 32'd0);
        check_eq("t5_rgb", 32'({a_if.IN_R, a_if.IN_G, a_if.IN_B}), 32'd0);
        fifo_a.delete();
        exp_a.delete();
        exp_idx_a = 0;
        for (int i = 0; i < 12; i++) push_px_a(24'h330000 + 24'(i));
        frame_a(200);
        check_eq("t5_sb", 32'(exp_a.size()), 32'd0);

        // 6: no line gap, 2x2 frame at one pixel per clock.
        for (int i = 0; i < 4; i++) begin
            e.data = data_b + 24'(i);
            e.x    = 12'(i % 2);
            e.y    = 12'(i / 2);
            exp_b.push_back(e);
        end
        fd0 = fd_cnt_b;
        START_B = 1'b1;
        step();
        START_B = 1'b0;
        n = 0;
        while (fd_cnt_b == fd0 && n < 100) begin
            step();
            n++;
        end
        check_eq("t6_done", 32'(fd_cnt_b - fd0), 32'd1);
        check_eq("t6_count", 32'(cons_cyc_b.size()), 32'd4);
        if (cons_cyc_b.size() == 4)
            check_eq("t6_back2back", 32'(cons_cyc_b[3] - cons_cyc_b[0]), 32'd3);
        check_eq("t6_pops", 32'(pop_cnt_b), 32'd4);
        check_eq("t6_err", 32'(ERR_B), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
